// File: rtl/beta_pipe_pkg.sv
// Shared tag definitions for the Beta pipeline: destination-tag pipe, operand bypass and datapath.
// A tag is {LD flag, LDR flag, 5-bit destination}; R31 as destination means "no write".
package beta_pipe_pkg;

   localparam int          TAG_W      = 7;
   localparam int          LD_BIT     = 6;
   localparam int          LDR_BIT    = 5;
   localparam logic [6:0]  BUBBLE_TAG = 7'h1F;
   localparam logic [4:0]  R31        = 5'd31;

   typedef logic [TAG_W-1:0] tag_t;

   typedef struct packed {
      logic       is_ld;
      logic       is_ldr;
      logic [4:0] dest;
   } tag_fields_t;

   function automatic logic [4:0] tag_dest(input tag_t tag);
      return tag[4:0];
   endfunction

endpackage

// File: rtl/beta_tag_stage.sv
// One pipeline stage of the destination tag: a TAG_W register that resets to a bubble
// and either holds its value or loads load_val on each clock edge.
module beta_tag_stage
   import beta_pipe_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hold,
   input  logic [TAG_W-1:0] load_val,
   output logic [TAG_W-1:0] tag_q
);

   logic [TAG_W-1:0] tag_d;

   always_comb begin
      tag_d = load_val;
      if (hold) begin
         tag_d = tag_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_q <= BUBBLE_TAG;
      end else begin
         tag_q <= tag_d;
      end
   end

endmodule

// File: rtl/beta_dest_tag_pipe.sv
// Destination-tag pipeline and stall sequencer for the 5-stage Beta (ALU/MEM/WB tags, fetch hold, RF write port).
// Optional hazard counters (stall_cnt, bubble_cnt) are built when BETA_HAZARD_STATS_EN is defined.
module beta_dest_tag_pipe
   import beta_pipe_pkg::*;
#(
   parameter int AW = 5
`ifdef BETA_HAZARD_STATS_EN
   ,
   parameter int STAT_W = 32
`endif
)
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inst_valid,
   input  logic [AW-1:0] rc,
   input  logic          writes_rc,
   input  logic          is_ld,
   input  logic          is_ldr,
   input  logic          stall_a,
   input  logic          stall_b,
   input  logic          annul,
   input  logic          mem_wait,
   output logic [6:0]    aP0,
   output logic [6:0]    aP1,
   output logic [6:0]    aP2,
   output logic          hold_fetch,
   output logic          rf_we,
   output logic [AW-1:0] rf_wa
`ifdef BETA_HAZARD_STATS_EN
   ,
   output logic [STAT_W-1:0] stall_cnt,
   output logic [STAT_W-1:0] bubble_cnt
`endif
);

   logic       stall_any;
   logic       insert_bubble;
   logic [6:0] new_tag;
   logic [6:0] alu_load;

   // Annul beats stall: a killed instruction has nothing to wait for, so fetch may proceed.
   always_comb begin
      stall_any     = stall_a | stall_b;
      insert_bubble = annul | stall_any;
      new_tag       = BUBBLE_TAG;
      if (inst_valid && writes_rc) begin
         new_tag = {is_ld, is_ldr, rc};
      end
      alu_load   = insert_bubble ? BUBBLE_TAG : new_tag;
      hold_fetch = mem_wait | (stall_any & ~annul);
      rf_wa      = aP2[AW-1:0];
      rf_we      = (tag_dest(aP2) != R31) & ~mem_wait;
   end

   beta_tag_stage u_alu (
      .clk      (clk),
      .rst_n    (rst_n),
      .hold     (mem_wait),
      .load_val (alu_load),
      .tag_q    (aP0)
   );

   beta_tag_stage u_mem (
      .clk      (clk),
      .rst_n    (rst_n),
      .hold     (mem_wait),
      .load_val (aP0),
      .tag_q    (aP1)
   );

   beta_tag_stage u_wb (
      .clk      (clk),
      .rst_n    (rst_n),
      .hold     (mem_wait),
      .load_val (aP1),
      .tag_q    (aP2)
   );

   a_ld_ldr_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
      !(inst_valid && writes_rc && is_ld && is_ldr));

`ifdef BETA_HAZARD_STATS_EN
   logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [STAT_W-1:0] bubble_cnt_q, bubble_cnt_d;

   // Both counters saturate at all-ones rather than wrapping.
   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (stall_any && !annul && !mem_wait && !(&stall_cnt_q)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (insert_bubble && !mem_wait && !(&bubble_cnt_q)) begin
         bubble_cnt_d = bubble_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_beta_dest_tag_pipe.sv
// Self-checking bench for beta_dest_tag_pipe: directed vectors, a queue-style tag model
// compared every cycle, and literal expectations at key points.
module tb_beta_dest_tag_pipe;

   logic       clk;
   logic       rst_n;
   logic       inst_valid;
   logic [4:0] rc;
   logic       writes_rc;
   logic       is_ld;
   logic       is_ldr;
   logic       stall_a;
   logic       stall_b;
   logic       annul;
   logic       mem_wait;
   logic [6:0] aP0, aP1, aP2;
   logic       hold_fetch;
   logic       rf_we;
   logic [4:0] rf_wa;

   int checks;
   int failures;
   logic [6:0] model_tag [3];
   bit compare_en;

   beta_dest_tag_pipe #(.AW(5)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .inst_valid (inst_valid),
      .rc         (rc),
      .writes_rc  (writes_rc),
      .is_ld      (is_ld),
      .is_ldr     (is_ldr),
      .stall_a    (stall_a),
      .stall_b    (stall_b),
      .annul      (annul),
      .mem_wait   (mem_wait),
      .aP0        (aP0),
      .aP1        (aP1),
      .aP2        (aP2),
      .hold_fetch (hold_fetch),
      .rf_we      (rf_we),
      .rf_wa      (rf_wa)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: three pipeline slots; index 0 is the ALU stage.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) model_tag[i] = 7'h1F;
      end else if (!mem_wait) begin
         model_tag[2] = model_tag[1];
         model_tag[1] = model_tag[0];
         if (annul || stall_a || stall_b)
            model_tag[0] = 7'h1F;
         else if (inst_valid && writes_rc)
            model_tag[0] = {is_ld, is_ldr, rc};
         else
            model_tag[0] = 7'h1F;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      if (compare_en) begin
         logic [4:0] wb_dest;
         wb_dest = model_tag[2][4:0];
         checkOutput("model_aP0", aP0, model_tag[0]);
         checkOutput("model_aP1", aP1, model_tag[1]);
         checkOutput("model_aP2", aP2, model_tag[2]);
         checkOutput("model_hold_fetch", hold_fetch, mem_wait || ((stall_a || stall_b) && !annul));
         checkOutput("model_rf_we", rf_we, (wb_dest != 5'd31) && !mem_wait);
         checkOutput("model_rf_wa", rf_wa, wb_dest);
      end
   end

   task automatic setInputs(input logic v, input logic [4:0] r, input logic w, input logic ld,
                            input logic ldr, input logic sa, input logic sb, input logic an,
                            input logic mw);
      inst_valid = v;
      rc         = r;
      writes_rc  = w;
      is_ld      = ld;
      is_ldr     = ldr;
      stall_a    = sa;
      stall_b    = sb;
      annul      = an;
      mem_wait   = mw;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [4:0] r, input logic w, input logic ld,
                                input logic ldr, input logic sa, input logic sb, input logic an,
                                input logic mw);
      setInputs(v, r, w, ld, ldr, sa, sb, an, mw);
      tick();
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      compare_en = 1'b0;
      rst_n      = 1'b0;
      setInputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      checkOutput("reset_aP0", aP0, 7'h1F);
      checkOutput("reset_aP2", aP2, 7'h1F);
      checkOutput("reset_rf_we", rf_we, 1'b0);
      rst_n = 1'b1;
      compare_en = 1'b1;

      // Plain flow: ADD R3
      applyStimulus(1, 5'd3, 1, 0, 0, 0, 0, 0, 0);
      checkOutput("flow_aP0", aP0, 7'h03);
      applyStimulus(0, 5'd0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("flow_aP1", aP1, 7'h03);
      applyStimulus(0, 5'd0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("flow_aP2", aP2, 7'h03);
      checkOutput("flow_rf_we", rf_we, 1'b1);
      checkOutput("flow_rf_wa", rf_wa, 5'd3);

      // LD-use: LD R4 then dependent ADD R6 stalled twice
      applyStimulus(1, 5'd4, 1, 1, 0, 0, 0, 0, 0);
      checkOutput("ld_aP0", aP0, 7'h44);
      setInputs(1, 5'd6, 1, 0, 0, 1, 0, 0, 0);
      checkOutput("ld_hold1", hold_fetch, 1'b1);
      tick();
      checkOutput("ld_stall1_aP0", aP0, 7'h1F);
      checkOutput("ld_stall1_aP1", aP1, 7'h44);
      setInputs(1, 5'd6, 1, 0, 0, 1, 0, 0, 0);
      checkOutput("ld_hold2", hold_fetch, 1'b1);
      tick();
      checkOutput("ld_stall2_aP0", aP0, 7'h1F);
      checkOutput("ld_stall2_aP2", aP2, 7'h44);
      applyStimulus(1, 5'd6, 1, 0, 0, 0, 0, 0, 0);
      checkOutput("ld_consumer_aP0", aP0, 7'h06);

      // mem_wait freeze with aP1=05, aP2=02
      applyStimulus(1, 5'd2, 1, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 5'd5, 1, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 5'd9, 1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         setInputs(1, 5'd11, 1, 0, 0, 0, 0, 0, 1);
         checkOutput("mw_rf_we", rf_we, 1'b0);
         checkOutput("mw_hold", hold_fetch, 1'b1);
         tick();
         checkOutput("mw_aP1", aP1, 7'h05);
         checkOutput("mw_aP2", aP2, 7'h02);
      end
      setInputs(1, 5'd11, 1, 0, 0, 0, 0, 0, 0);
      checkOutput("mw_release_rf_we", rf_we, 1'b1);
      checkOutput("mw_release_rf_wa", rf_wa, 5'd2);
      tick();
      checkOutput("mw_release_aP0", aP0, 7'h0B);
      checkOutput("mw_release_aP2", aP2, 7'h05);

      // annul together with stall_b
      setInputs(1, 5'd12, 1, 0, 0, 0, 1, 1, 0);
      checkOutput("annul_hold", hold_fetch, 1'b0);
      tick();
      checkOutput("annul_aP0", aP0, 7'h1F);

      // ST R7 (no write)
      applyStimulus(1, 5'd7, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("st_aP0", aP0, 7'h1F);
      applyStimulus(0, 5'd0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 5'd0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("st_aP2", aP2, 7'h1F);
      checkOutput("st_rf_we", rf_we, 1'b0);

      // Reset mid-cycle with non-bubble tags in flight
      applyStimulus(1, 5'd1, 1, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 5'd2, 1, 0, 1, 0, 0, 0, 0);
      applyStimulus(1, 5'd3, 1, 0, 0, 0, 0, 0, 0);
      checkOutput("pre_reset_aP1", aP1, 7'h22);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset_aP0", aP0, 7'h1F);
      checkOutput("async_reset_aP1", aP1, 7'h1F);
      checkOutput("async_reset_aP2", aP2, 7'h1F);
      checkOutput("async_reset_rf_we", rf_we, 1'b0);
      tick();
      compare_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/beta_dest_tag_pipe.md
Name: beta_dest_tag_pipe

Overview:
- Destination-tag pipeline and stall sequencer for the 5-stage Beta. Sits upstream of the two operand-bypass instances (Ra, Rb).
- Each cycle it captures the destination register and load flags of the RF-stage instruction and shifts them through ALU, MEM and WB. These become the 7-bit tags aP0/aP1/aP2 the bypass compares against.
- It consumes the bypass stall outputs, bubbles the ALU stage, holds fetch/RF, and drives the register-file write port from the WB tag.

Parameters:
- AW, 5, register address width.
- STAT_W, 32, stall/bubble counter width (optional feature only).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- inst_valid  in  1  RF stage holds a real instruction
- rc  in  AW  destination register of RF-stage instruction
- writes_rc  in  1  instruction writes rc (0 for ST, BEQ/BNE with Rc=31, etc.)
- is_ld  in  1  instruction is LD
- is_ldr  in  1  instruction is LDR
- stall_a  in  1  stall from Ra bypass
- stall_b  in  1  stall from Rb bypass
- annul  in  1  kill the RF-stage instruction (taken branch/JMP)
- mem_wait  in  1  data memory not ready; freeze the whole pipe
- aP0  out  7  ALU-stage tag {is_ld, is_ldr, rc}
- aP1  out  7  MEM-stage tag
- aP2  out  7  WB-stage tag
- hold_fetch  out  1  hold PC and the IF/RF instruction register
- rf_we  out  1  register-file write enable
- rf_wa  out  AW  register-file write address

Behaviour:
- Tag format: [6] = LD, [5] = LDR, [4:0] = dest. BUBBLE = 7'h1F (dest R31, flags clear).
- new_tag = (inst_valid & writes_rc) ? {is_ld, is_ldr, rc} : BUBBLE.
  - writes_rc=0 forces BUBBLE regardless of the flags.
  - is_ld & is_ldr together is illegal: assertion fires; the value passes through unchanged.
- stall_any = stall_a | stall_b.
- Reset (async, rst_n=0): aP0=aP1=aP2=BUBBLE immediately. Hence rf_we=0, rf_wa=31, hold_fetch follows its equation. Reset mid-operation discards all in-flight tags.
- Per rising edge, priority order:
  1. mem_wait=1: aP0/aP1/aP2 hold.
  2. annul=1: aP2<=aP1, aP1<=aP0, aP0<=BUBBLE. Annul overrides stall because the killed instruction need not wait.
  3. stall_any=1: same shift, aP0<=BUBBLE; the RF instruction is held and re-presented next cycle.
  4. Otherwise: aP2<=aP1, aP1<=aP0, aP0<=new_tag.
- hold_fetch = mem_wait | (stall_any & ~annul). Combinational, zero latency, no register in the path.
- rf_we = (aP2[4:0] != 31) & ~mem_wait. rf_wa = aP2[4:0]. Both combinational.
- Latency: an RF-stage tag appears on aP0 one cycle later, aP1 two, aP2 three (absent freeze/stall).
- LD-use hazard:
  - Dependent instruction directly behind LD: stall for 2 cycles, until the LD tag reaches aP2.
  - Dependent instruction one behind: stall 1 cycle.
- No combinational path from stall_a/stall_b back to aP*. aP* are pure flops, so the bypass stall→hold loop is acyclic.
- Datapath convention: a stage result carrying dest R31 is forced to 0 by the datapath, so bypassing a BUBBLE to an R31 read yields 0.

Optional Feature:
- Macro BETA_HAZARD_STATS_EN.
- Defined: adds outputs stall_cnt[STAT_W] and bubble_cnt[STAT_W]. Both reset to 0.
  - stall_cnt increments on cycles with stall_any & ~annul & ~mem_wait.
  - bubble_cnt increments whenever a non-new_tag BUBBLE enters aP0 (annul or stall, not mem_wait).
  - Both saturate at all-ones.
- Undefined: ports and logic absent; core behaviour identical.

Decomposition:
- Package beta_pipe_pkg:
  - TAG_W=7, LD_BIT=6, LDR_BIT=5, BUBBLE_TAG=7'h1F, R31=5'd31.
  - typedef for the tag struct/packed vector.
  - Shared with the bypass and the datapath.
- One sub-module, beta_tag_stage: a single TAG_W register with async active-low reset to BUBBLE_TAG, a hold input and a load-value input. Instantiated three times.

Test Plan:
- Reset: run tags with aP0..aP2 non-bubble, drop rst_n mid-cycle → all aP* = 7'h1F and rf_we=0 immediately, before the next clk edge.
- Plain flow: ADD R3 (writes_rc=1, rc=3) with no stall → aP0=7'h03 at +1, aP1 at +2, aP2 at +3 with rf_we=1, rf_wa=3.
- LD-use:
  - LD R4 (is_ld=1) → aP0=7'h44.
  - Bench bypass asserts stall_a for the next consumer → hold_fetch=1, aP0<=7'h1F, aP1=7'h44.
  - Still stalled (aP1 flag) → second bubble, aP2=7'h44.
  - Stall drops → consumer tag enters aP0.
- mem_wait held 3 cycles with aP1=7'h05, aP2=7'h02 → tags frozen, rf_we=0 all 3 cycles, hold_fetch=1. Release → shift resumes, rf_we=1 for R2 on the first unfrozen cycle.
- annul and stall_b together → hold_fetch=0, aP0<=7'h1F. ST (writes_rc=0, rc=7) → tag 7'h1F, rf_we=0 three cycles later.
- With BETA_HAZARD_STATS_EN, the LD-use case plus one annul → stall_cnt=2, bubble_cnt=3.
